// File: rtl/alu_issue_queue.sv
// Age-ordered collapsing issue queue between dispatch and the ALU; index 0 is the oldest entry.
// Optional macro IQ_FAST_WAKEUP_EN: wakeup hits are visible to select and issue_inst in the same cycle.
module alu_issue_queue #(
    parameter int DEPTH        = 8,
    parameter int PHY_REG_W    = 6,
    parameter int WAKEUP_PORTS = 2,
    parameter int INST_W       = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   flush,
    input  logic                                   dispatch_valid,
    output logic                                   iq_allowin,
    input  logic [INST_W-1:0]                      dispatch_inst,
    input  logic [PHY_REG_W-1:0]                   dispatch_phy_dest,
    input  logic [PHY_REG_W-1:0]                   dispatch_src1_tag,
    input  logic [PHY_REG_W-1:0]                   dispatch_src2_tag,
    input  logic                                   dispatch_src1_ready,
    input  logic                                   dispatch_src2_ready,
    input  logic [31:0]                            dispatch_src1_value,
    input  logic [31:0]                            dispatch_src2_value,
    input  logic [WAKEUP_PORTS*(36+PHY_REG_W)-1:0] wakeup_bus,
    output logic                                   issue_to_alu_valid,
    input  logic                                   alu_allowin,
    output logic [INST_W+PHY_REG_W+63:0]           issue_inst,
    output logic [$clog2(DEPTH):0]                 iq_count
);
    localparam int BUS_W = 36 + PHY_REG_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OPS   = 2 * DEPTH + 2;
`ifdef IQ_FAST_WAKEUP_EN
    localparam bit FAST_WAKEUP = 1'b1;
`else
    localparam bit FAST_WAKEUP = 1'b0;
`endif

    // Operand k of entry i lives at index 2*i+k of the operand arrays.
    logic                 valid_reg [DEPTH];
    logic [INST_W-1:0]    inst_reg  [DEPTH];
    logic [PHY_REG_W-1:0] dest_reg  [DEPTH];
    logic [PHY_REG_W-1:0] tag_reg   [2*DEPTH];
    logic                 rdy_reg   [2*DEPTH];
    logic [31:0]          val_reg   [2*DEPTH];
    logic [CNT_W-1:0]     count_reg;

    logic                 bus_live [WAKEUP_PORTS];
    logic [PHY_REG_W-1:0] bus_tag  [WAKEUP_PORTS];
    logic [31:0]          bus_res  [WAKEUP_PORTS];

    // Operand slots 2*DEPTH and 2*DEPTH+1 are the two incoming dispatch operands.
    logic [PHY_REG_W-1:0] op_tag  [OPS];
    logic                 op_rdy  [OPS];
    logic [31:0]          op_val  [OPS];
    logic                 cap_rdy [OPS];
    logic [31:0]          cap_val [OPS];
    logic                 eff_rdy [2*DEPTH];
    logic [31:0]          eff_val [2*DEPTH];

    logic                 shift_valid [DEPTH];
    logic [INST_W-1:0]    shift_inst  [DEPTH];
    logic [PHY_REG_W-1:0] shift_dest  [DEPTH];
    logic [PHY_REG_W-1:0] shift_tag   [2*DEPTH];
    logic                 shift_rdy   [2*DEPTH];
    logic [31:0]          shift_val   [2*DEPTH];

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             issue_fire;
    logic             dispatch_fire;
    logic [CNT_W-1:0] wr_idx;

    genvar gi;
    generate
        for (gi = 0; gi < WAKEUP_PORTS; gi++) begin : g_port
            assign bus_res[gi]  = wakeup_bus[gi*BUS_W +: 32];
            assign bus_tag[gi]  = wakeup_bus[gi*BUS_W+32 +: PHY_REG_W];
            assign bus_live[gi] = |wakeup_bus[gi*BUS_W+32+PHY_REG_W +: 4];
        end

        for (gi = 0; gi < OPS; gi++) begin : g_op
            logic        hit_rdy;
            logic [31:0] hit_val;
            if (gi < 2*DEPTH) begin : g_entry
                assign op_tag[gi]  = tag_reg[gi];
                assign op_rdy[gi]  = rdy_reg[gi];
                assign op_val[gi]  = val_reg[gi];
                assign eff_rdy[gi] = FAST_WAKEUP ? hit_rdy : rdy_reg[gi];
                assign eff_val[gi] = FAST_WAKEUP ? hit_val : val_reg[gi];
            end else if (gi == 2*DEPTH) begin : g_disp1
                assign op_tag[gi] = dispatch_src1_tag;
                assign op_rdy[gi] = dispatch_src1_ready;
                assign op_val[gi] = dispatch_src1_value;
            end else begin : g_disp2
                assign op_tag[gi] = dispatch_src2_tag;
                assign op_rdy[gi] = dispatch_src2_ready;
                assign op_val[gi] = dispatch_src2_value;
            end

            // Scan high to low so the lowest matching port has the final say.
            always_comb begin
                hit_rdy = op_rdy[gi];
                hit_val = op_val[gi];
                for (int p = WAKEUP_PORTS - 1; p >= 0; p--) begin
                    if (!op_rdy[gi] && bus_live[p] && bus_tag[p] == op_tag[gi]) begin
                        hit_rdy = 1'b1;
                        hit_val = bus_res[p];
                    end
                end
            end
            assign cap_rdy[gi] = hit_rdy;
            assign cap_val[gi] = hit_val;
        end

        for (gi = 0; gi < DEPTH; gi++) begin : g_shift
            if (gi < DEPTH - 1) begin : g_mid
                assign shift_valid[gi]    = valid_reg[gi+1];
                assign shift_inst[gi]     = inst_reg[gi+1];
                assign shift_dest[gi]     = dest_reg[gi+1];
                assign shift_tag[2*gi]    = tag_reg[2*gi+2];
                assign shift_tag[2*gi+1]  = tag_reg[2*gi+3];
                assign shift_rdy[2*gi]    = cap_rdy[2*gi+2];
                assign shift_rdy[2*gi+1]  = cap_rdy[2*gi+3];
                assign shift_val[2*gi]    = cap_val[2*gi+2];
                assign shift_val[2*gi+1]  = cap_val[2*gi+3];
            end else begin : g_top
                assign shift_valid[gi]    = 1'b0;
                assign shift_inst[gi]     = '0;
                assign shift_dest[gi]     = '0;
                assign shift_tag[2*gi]    = '0;
                assign shift_tag[2*gi+1]  = '0;
                assign shift_rdy[2*gi]    = 1'b0;
                assign shift_rdy[2*gi+1]  = 1'b0;
                assign shift_val[2*gi]    = '0;
                assign shift_val[2*gi+1]  = '0;
            end
        end
    endgenerate

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_reg[i] && eff_rdy[2*i] && eff_rdy[2*i+1]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_to_alu_valid = sel_found;
    assign issue_inst = sel_found ? {inst_reg[sel_idx], dest_reg[sel_idx],
                                     eff_val[{sel_idx, 1'b0}], eff_val[{sel_idx, 1'b1}]} : '0;
    assign iq_allowin    = (count_reg < CNT_W'(DEPTH)) && !flush;
    assign iq_count      = count_reg;
    assign issue_fire    = sel_found && alu_allowin;
    assign dispatch_fire = dispatch_valid && iq_allowin;
    assign wr_idx        = count_reg - CNT_W'(issue_fire);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_reg[i] <= 1'b0;
                inst_reg[i]  <= '0;
                dest_reg[i]  <= '0;
            end
            for (int k = 0; k < 2*DEPTH; k++) begin
                tag_reg[k] <= '0;
                rdy_reg[k] <= 1'b0;
                val_reg[k] <= '0;
            end
        end else if (flush) begin
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) valid_reg[i] <= 1'b0;
        end else begin
            count_reg <= count_reg + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
            for (int i = 0; i < DEPTH; i++) begin
                if (dispatch_fire && CNT_W'(i) == wr_idx) begin
                    valid_reg[i]   <= 1'b1;
                    inst_reg[i]    <= dispatch_inst;
                    dest_reg[i]    <= dispatch_phy_dest;
                    tag_reg[2*i]   <= dispatch_src1_tag;
                    tag_reg[2*i+1] <= dispatch_src2_tag;
                    rdy_reg[2*i]   <= cap_rdy[2*DEPTH];
                    rdy_reg[2*i+1] <= cap_rdy[2*DEPTH+1];
                    val_reg[2*i]   <= cap_val[2*DEPTH];
                    val_reg[2*i+1] <= cap_val[2*DEPTH+1];
                end else if (issue_fire && IDX_W'(i) >= sel_idx) begin
                    valid_reg[i]   <= shift_valid[i];
                    inst_reg[i]    <= shift_inst[i];
                    dest_reg[i]    <= shift_dest[i];
                    tag_reg[2*i]   <= shift_tag[2*i];
                    tag_reg[2*i+1] <= shift_tag[2*i+1];
                    rdy_reg[2*i]   <= shift_rdy[2*i];
                    rdy_reg[2*i+1] <= shift_rdy[2*i+1];
                    val_reg[2*i]   <= shift_val[2*i];
                    val_reg[2*i+1] <= shift_val[2*i+1];
                end else begin
                    rdy_reg[2*i]   <= cap_rdy[2*i];
                    rdy_reg[2*i+1] <= cap_rdy[2*i+1];
                    val_reg[2*i]   <= cap_val[2*i];
                    val_reg[2*i+1] <= cap_val[2*i+1];
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized and directed bench for alu_issue_queue: a queue-based reference model predicts
// issues, a separate monitor checks every issued instruction against the scoreboard.
`timescale 1ns/1ps
module tb_alu_issue_queue;
    localparam int DEPTH = 8;
    localparam int PW    = 6;
    localparam int NP    = 2;
    localparam int IW    = 32;
    localparam int BUS_W = 36 + PW;
    localparam int CNT_W = 4;
    localparam int ISS_W = IW + PW + 64;
`ifdef IQ_FAST_WAKEUP_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, flush, dispatch_valid, iq_allowin;
    logic [IW-1:0]     dispatch_inst;
    logic [PW-1:0]     dispatch_phy_dest, dispatch_src1_tag, dispatch_src2_tag;
    logic              dispatch_src1_ready, dispatch_src2_ready;
    logic [31:0]       dispatch_src1_value, dispatch_src2_value;
    logic [NP*BUS_W-1:0] wakeup_bus;
    logic              issue_to_alu_valid, alu_allowin;
    logic [ISS_W-1:0]  issue_inst;
    logic [CNT_W-1:0]  iq_count;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(DEPTH), .PHY_REG_W(PW), .WAKEUP_PORTS(NP), .INST_W(IW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .iq_allowin(iq_allowin),
        .dispatch_inst(dispatch_inst), .dispatch_phy_dest(dispatch_phy_dest),
        .dispatch_src1_tag(dispatch_src1_tag), .dispatch_src2_tag(dispatch_src2_tag),
        .dispatch_src1_ready(dispatch_src1_ready), .dispatch_src2_ready(dispatch_src2_ready),
        .dispatch_src1_value(dispatch_src1_value), .dispatch_src2_value(dispatch_src2_value),
        .wakeup_bus(wakeup_bus), .issue_to_alu_valid(issue_to_alu_valid),
        .alu_allowin(alu_allowin), .issue_inst(issue_inst), .iq_count(iq_count)
    );

    typedef struct {
        logic [IW-1:0] inst;
        logic [PW-1:0] dest, t1, t2;
        logic          r1, r2;
        logic [31:0]   v1, v2;
    } ent_t;

    logic [3:0]       w_we  [NP];
    logic [PW-1:0]    w_tag [NP];
    logic [31:0]      w_res [NP];
    ent_t             mq[$];
    logic [ISS_W-1:0] exp_q[$];
    int               checks = 0;
    int               failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Lowest-numbered live port carrying the operand's tag supplies the value.
    function automatic ent_t wake(input ent_t e);
        ent_t r;
        r = e;
        if (!r.r1)
            for (int p = 0; p < NP; p++)
                if (w_we[p] != 4'h0 && w_tag[p] == r.t1) begin r.r1 = 1'b1; r.v1 = w_res[p]; break; end
        if (!r.r2)
            for (int p = 0; p < NP; p++)
                if (w_we[p] != 4'h0 && w_tag[p] == r.t2) begin r.r2 = 1'b1; r.v2 = w_res[p]; break; end
        return r;
    endfunction

    task automatic idle();
        flush = 0; dispatch_valid = 0; dispatch_inst = '0; dispatch_phy_dest = '0;
        dispatch_src1_tag = '0; dispatch_src2_tag = '0;
        dispatch_src1_ready = 0; dispatch_src2_ready = 0;
        dispatch_src1_value = '0; dispatch_src2_value = '0;
        for (int p = 0; p < NP; p++) begin w_we[p] = '0; w_tag[p] = '0; w_res[p] = '0; end
    endtask

    task automatic disp_ready(input logic [31:0] inst, input logic [31:0] v1, input logic [31:0] v2);
        dispatch_valid = 1; dispatch_inst = inst; dispatch_phy_dest = PW'(inst);
        dispatch_src1_tag = 6'd1; dispatch_src2_tag = 6'd2;
        dispatch_src1_ready = 1; dispatch_src2_ready = 1;
        dispatch_src1_value = v1; dispatch_src2_value = v2;
    endtask

    // One clock: settle inputs, predict with the model, advance it, check the counters.
    task automatic step();
        ent_t cap[$];
        ent_t eff;
        ent_t nd;
        int   sel;
        logic allow, ifire, dfire;
        for (int p = 0; p < NP; p++) wakeup_bus[p*BUS_W +: BUS_W] = {w_we[p], w_tag[p], w_res[p]};
        #1;
        sel = -1;
        foreach (mq[i]) cap.push_back(wake(mq[i]));
        for (int i = 0; i < mq.size(); i++) begin
            if (FAST) eff = cap[i]; else eff = mq[i];
            if (eff.r1 && eff.r2) begin sel = i; break; end
        end
        allow = (mq.size() < DEPTH) && !flush;
        check("iq_allowin", 128'(iq_allowin), 128'(allow));
        check("issue_valid", 128'(issue_to_alu_valid), 128'(sel >= 0));
        ifire = (sel >= 0) && alu_allowin && !flush;
        dfire = dispatch_valid && allow;
        if (ifire) begin
            if (FAST) eff = cap[sel]; else eff = mq[sel];
            exp_q.push_back({eff.inst, eff.dest, eff.v1, eff.v2});
        end
        if (flush) mq.delete();
        else begin
            mq = cap;
            if (ifire) mq.delete(sel);
            if (dfire) begin
                nd.inst = dispatch_inst; nd.dest = dispatch_phy_dest;
                nd.t1 = dispatch_src1_tag; nd.t2 = dispatch_src2_tag;
                nd.r1 = dispatch_src1_ready; nd.r2 = dispatch_src2_ready;
                nd.v1 = dispatch_src1_value; nd.v2 = dispatch_src2_value;
                mq.push_back(wake(nd));
            end
        end
        @(posedge clk);
        #1;
        check("iq_count", 128'(iq_count), 128'(mq.size()));
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL issue_missing actual=not_issued expected=%0d_issues", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every accepted issue must match the oldest outstanding prediction.
    initial begin
        logic [ISS_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && !flush && issue_to_alu_valid && alu_allowin) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL issue_unexpected actual=%h expected=none", issue_inst);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_inst", 128'(issue_inst), 128'(e));
                end
            end
        end
    end

    initial begin
        idle();
        alu_allowin = 1;
        wakeup_bus = '0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        #1;
        check("reset_count", 128'(iq_count), 128'(0));
        check("reset_valid", 128'(issue_to_alu_valid), 128'(0));
        check("reset_allowin", 128'(iq_allowin), 128'(1));

        // Single ready ADDU
        disp_ready(32'h0000_0021, 32'd5, 32'd7);
        step();
        idle();
        repeat (2) step();

        // Wakeup capture through port 1
        disp_ready(32'h0000_0023, 32'd3, 32'd0);
        dispatch_src2_tag = 6'd9; dispatch_src2_ready = 0;
        step();
        idle();
        w_we[1] = 4'hF; w_tag[1] = 6'd9; w_res[1] = 32'hDEAD_BEEF;
        step();
        idle();
        repeat (2) step();

        // Fill with backpressure, then drain while dispatching
        alu_allowin = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            disp_ready(32'h100 + 32'(i), $urandom, $urandom);
            step();
        end
        alu_allowin = 1;
        for (int i = 0; i < 4; i++) begin
            disp_ready(32'h200 + 32'(i), $urandom, $urandom);
            step();
        end
        idle();
        repeat (14) step();

        // Flush with a simultaneous dispatch
        alu_allowin = 0;
        for (int i = 0; i < 4; i++) begin disp_ready(32'h300 + 32'(i), 32'(i), 32'(i)); step(); end
        alu_allowin = 1; flush = 1;
        step();
        idle();
        step();

        // Asynchronous reset between edges with 5 entries held
        alu_allowin = 0;
        for (int i = 0; i < 5; i++) begin disp_ready(32'h400 + 32'(i), 32'(i), 32'(i)); step(); end
        idle();
        #2 reset = 1;
        #1;
        check("async_count", 128'(iq_count), 128'(0));
        check("async_valid", 128'(issue_to_alu_valid), 128'(0));
        check("async_inst", 128'(issue_inst), 128'(0));
        @(posedge clk);
        #1 reset = 0;
        mq.delete();
        exp_q.delete();
        alu_allowin = 1;
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            dispatch_valid = ($urandom_range(0, 9) < 6);
            dispatch_inst = $urandom;
            dispatch_phy_dest = PW'($urandom_range(0, 63));
            dispatch_src1_tag = PW'($urandom_range(0, 15));
            dispatch_src2_tag = PW'($urandom_range(0, 15));
            dispatch_src1_ready = 1'($urandom_range(0, 1));
            dispatch_src2_ready = 1'($urandom_range(0, 1));
            dispatch_src1_value = $urandom;
            dispatch_src2_value = $urandom;
            for (int p = 0; p < NP; p++) begin
                w_we[p]  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                w_tag[p] = PW'($urandom_range(0, 15));
                w_res[p] = $urandom;
            end
            alu_allowin = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 99) == 0);
            step();
        end
        idle();
        flush = 1;
        step();
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
